// File: rtl/branch_pkg.sv
// Shared types and constants for the fetch-side branch / program-counter unit.
//   br_type_e  : decoded branch kind carried on br_type
//   pc_state_e : run/halt control state of the core
//   br_taken() : evaluates a branch kind against the registered compare flags
package branch_pkg;

    // Reserved branch encoding; it behaves exactly like BR_NONE.
    localparam logic [2:0] BR_RESERVED_ENC = 3'b111;

    // PC value loaded on reset and on every start.
    localparam int unsigned RESET_PC = 0;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BLE  = 3'b100,
        BR_BGT  = 3'b101,
        BR_JMP  = 3'b110,
        BR_RSVD = BR_RESERVED_ENC
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    function automatic logic br_taken(input br_type_e kind, input logic eq, input logic lt);
        logic taken;
        case (kind)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt;
            BR_BLE:  taken = lt | eq;
            BR_BGT:  taken = !lt & !eq;
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;   // NONE and the reserved encoding
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_target_lut.sv
// Branch target look-up table: 2**IDX_W absolute target PCs.
//   clk, rst_n : clock, asynchronous active-low reset (all entries clear to 0)
//   we, waddr, wdata : single write port, takes effect on the rising edge
//   raddr, rdata     : combinational read port; a same-cycle write to the
//                      same index is not visible until the next cycle
module branch_target_lut #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign mem_d[gi] = (we && (waddr == IDX_W'(gi))) ? wdata : mem_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch-side branch / program-counter unit of the 8-bit core.
// Latches the ALU compare flags, evaluates the decoded branch condition on the
// registered flags, and advances the PC (pc+1 or a target from the LUT).
// Also owns the IDLE / RUN / HALTED control FSM.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin execution at PC 0 (ignored in RUN)
//   stall               : freeze PC, flags and FSM for this cycle
//   halt_req            : current instruction is HALT (RUN only)
//   flag_we, alu_equal, alu_less_than : flag register write (RUN only)
//   br_type, br_idx     : decoded branch kind and target LUT index
//   lut_we, lut_waddr, lut_wdata : target LUT write port (any state)
//   pc                  : current instruction address
//   running, done       : state is RUN / state is HALTED
//   flag_eq, flag_lt    : registered compare flags
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 flag_we,
    input  logic                 alu_equal,
    input  logic                 alu_less_than,
    input  logic [2:0]           br_type,
    input  logic [LUT_IDX_W-1:0] br_idx,
    input  logic                 lut_we,
    input  logic [LUT_IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]      lut_wdata,
    output logic [PC_W-1:0]      pc,
    output logic                 running,
    output logic                 done,
    output logic                 flag_eq,
    output logic                 flag_lt
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flag_eq_q, flag_eq_d;
    logic            flag_lt_q, flag_lt_d;
    logic [PC_W-1:0] lut_rdata;
    logic            taken;

    branch_target_lut #(
        .IDX_W  (LUT_IDX_W),
        .DATA_W (PC_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (br_idx),
        .rdata (lut_rdata)
    );

    // Uses the registered flags, so a flag write in the same cycle is not seen.
    assign taken = br_taken(br_type_e'(br_type), flag_eq_q, flag_lt_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flag_eq_d = flag_eq_q;
        flag_lt_d = flag_lt_q;

        // A stall freezes everything, including a start request.
        if (!stall) begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state_d = ST_RUN;
                        pc_d    = PC_W'(RESET_PC);
                    end
                end
                ST_RUN: begin
                    if (flag_we) begin
                        flag_eq_d = alu_equal;
                        flag_lt_d = alu_less_than;
                    end
                    // HALT wins over any branch: the PC stays on the HALT.
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end else if (taken) begin
                        pc_d = lut_rdata;
                    end else begin
                        pc_d = pc_q + PC_W'(1);   // wraps modulo 2**PC_W
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pc_d    = PC_W'(RESET_PC);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_W'(RESET_PC);
            flag_eq_q <= 1'b0;
            flag_lt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flag_eq_q <= flag_eq_d;
            flag_lt_q <= flag_lt_d;
        end
    end

    assign pc      = pc_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_HALTED);
    assign flag_eq = flag_eq_q;
    assign flag_lt = flag_lt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit. Two instances share all stimulus:
// u_dut10 (PC_W=10) and u_dut4 (PC_W=4, for the PC wrap case).
module tb_branch_pc_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       halt_req = 1'b0;
    logic       flag_we = 1'b0;
    logic       alu_equal = 1'b0;
    logic       alu_less_than = 1'b0;
    logic [2:0] br_type = 3'd0;
    logic [3:0] br_idx = 4'd0;
    logic       lut_we = 1'b0;
    logic [3:0] lut_waddr = 4'd0;
    logic [9:0] lut_wdata = 10'd0;

    logic [9:0] pc10;
    logic       running10, done10, feq10, flt10;
    logic [3:0] pc4;
    logic       running4, done4, feq4, flt4;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    branch_pc_unit #(.PC_W(10), .LUT_IDX_W(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .halt_req(halt_req), .flag_we(flag_we), .alu_equal(alu_equal),
        .alu_less_than(alu_less_than), .br_type(br_type), .br_idx(br_idx),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .pc(pc10), .running(running10), .done(done10),
        .flag_eq(feq10), .flag_lt(flt10)
    );

    branch_pc_unit #(.PC_W(4), .LUT_IDX_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .halt_req(halt_req), .flag_we(flag_we), .alu_equal(alu_equal),
        .alu_less_than(alu_less_than), .br_type(br_type), .br_idx(br_idx),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata[3:0]),
        .pc(pc4), .running(running4), .done(done4),
        .flag_eq(feq4), .flag_lt(flt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    int m_state = M_IDLE;
    int m_pc = 0;
    int m_pc4 = 0;
    int m_eq = 0;
    int m_lt = 0;
    int m_lut [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE;
            m_pc = 0;
            m_pc4 = 0;
            m_eq = 0;
            m_lt = 0;
            for (int i = 0; i < 16; i++) m_lut[i] = 0;
        end else begin
            if (!stall) begin
                if (m_state != M_RUN) begin
                    if (start) begin
                        m_state = M_RUN;
                        m_pc = 0;
                        m_pc4 = 0;
                    end
                end else begin
                    bit go;
                    case (int'(br_type))
                        1: go = (m_eq != 0);
                        2: go = (m_eq == 0);
                        3: go = (m_lt != 0);
                        4: go = (m_lt != 0) || (m_eq != 0);
                        5: go = (m_lt == 0) && (m_eq == 0);
                        6: go = 1'b1;
                        default: go = 1'b0;
                    endcase
                    if (halt_req) begin
                        m_state = M_HALT;
                    end else if (go) begin
                        m_pc = m_lut[br_idx];
                        m_pc4 = m_lut[br_idx] % 16;
                    end else begin
                        m_pc = (m_pc + 1) % 1024;
                        m_pc4 = (m_pc4 + 1) % 16;
                    end
                    if (flag_we) begin
                        m_eq = int'(alu_equal);
                        m_lt = int'(alu_less_than);
                    end
                end
            end
            // LUT write after the PC decision: reads see the old entry.
            if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc10", 32'(pc10), 32'(m_pc));
            chk("pc4", 32'(pc4), 32'(m_pc4));
            chk("running", 32'(running10), 32'(m_state == M_RUN));
            chk("done", 32'(done10), 32'(m_state == M_HALT));
            chk("flags", {30'd0, feq10, flt10}, 32'((m_eq << 1) | m_lt));
            chk("dut4_ctl", {28'd0, running4, done4, feq4, flt4},
                {28'd0, running10, done10, feq10, flt10});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset, LUT preload, start
        step();
        step();
        cmp_en = 1'b1;
        chk("rst_pc", 32'(pc10), 32'h0);
        chk("rst_run_done", {30'd0, running10, done10}, 32'h0);
        chk("rst_flags", {30'd0, feq10, flt10}, 32'h0);
        rst_n = 1'b1;
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h040;
        step();
        lut_waddr = 4'd7; lut_wdata = 10'h3FF;
        step();
        lut_we = 1'b0;
        chk("idle_pc", 32'(pc10), 32'h0);
        chk("idle_running", 32'(running10), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_pc0", 32'(pc10), 32'h0);
        chk("start_running", 32'(running10), 32'h1);
        step(); chk("pc1", 32'(pc10), 32'h1);
        step(); chk("pc2", 32'(pc10), 32'h2);
        step(); chk("pc3", 32'(pc10), 32'h3);
        chk("run_done", 32'(done10), 32'h0);

        // 2: BEQ taken / BNE not taken
        flag_we = 1'b1; alu_equal = 1'b1; alu_less_than = 1'b0;
        step();
        flag_we = 1'b0;
        chk("flag_eq_set", {30'd0, feq10, flt10}, 32'h2);
        step();
        chk("pc5", 32'(pc10), 32'h5);
        br_type = 3'b001; br_idx = 4'd3;
        step();
        chk("beq_taken", 32'(pc10), 32'h040);
        br_type = 3'b010;
        step();
        chk("bne_not_taken", 32'(pc10), 32'h041);

        // 3: flag write + BLT in the same cycle sees old flags
        br_type = 3'b000;
        flag_we = 1'b1; alu_equal = 1'b0; alu_less_than = 1'b0;
        step();
        chk("flags_00", {30'd0, feq10, flt10}, 32'h0);
        alu_less_than = 1'b1; br_type = 3'b011;
        step();
        chk("blt_old_flags", 32'(pc10), 32'h043);
        flag_we = 1'b0;
        step();
        chk("blt_new_flags", 32'(pc10), 32'h040);
        br_type = 3'b000;

        // 4: 4-bit PC wrap, reserved encoding, BGT/BLE
        for (int i = 0; i < 15; i++) step();
        chk("pc4_all_ones", 32'(pc4), 32'hF);
        step();
        chk("pc4_wrap", 32'(pc4), 32'h0);
        br_type = 3'b111;
        step();
        chk("rsvd_is_none", 32'(pc4), 32'h1);
        br_type = 3'b101; br_idx = 4'd3;
        step();
        chk("bgt_not_taken", 32'(pc10), 32'h052);
        br_type = 3'b100; br_idx = 4'd7;
        step();
        chk("ble_taken", 32'(pc10), 32'h3FF);
        chk("ble_taken4", 32'(pc4), 32'hF);
        br_type = 3'b000;
        step();
        chk("pc10_wrap", 32'(pc10), 32'h0);

        // 5: stall beats halt; halt beats JMP; restart from HALTED
        stall = 1'b1; halt_req = 1'b1;
        flag_we = 1'b1; alu_equal = 1'b1; alu_less_than = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 32'(pc10), 32'h0);
            chk("stall_running", 32'(running10), 32'h1);
            chk("stall_flags", {30'd0, feq10, flt10}, 32'h1);
        end
        stall = 1'b0; flag_we = 1'b0; br_type = 3'b110; br_idx = 4'd3;
        step();
        chk("halt_done", {30'd0, running10, done10}, 32'h1);
        chk("halt_pc_hold", 32'(pc10), 32'h0);
        halt_req = 1'b0;
        step();
        chk("halted_stays", 32'(done10), 32'h1);
        br_type = 3'b000; start = 1'b1;
        step();
        chk("restart_pc", 32'(pc10), 32'h0);
        chk("restart_run_done", {30'd0, running10, done10}, 32'h2);
        step();
        start = 1'b0;
        chk("start_ignored_in_run", 32'(pc10), 32'h1);

        // 6: async reset mid-RUN at pc 0x2A with flags set
        flag_we = 1'b1; alu_equal = 1'b1; alu_less_than = 1'b1;
        step();
        flag_we = 1'b0;
        for (int i = 0; i < 200 && pc10 != 10'h02A; i++) step();
        chk("reach_2a", 32'(pc10), 32'h02A);
        chk("flags_11", {30'd0, feq10, flt10}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("areset_pc", 32'(pc10), 32'h0);
        chk("areset_flags", {30'd0, feq10, flt10}, 32'h0);
        chk("areset_state", {30'd0, running10, done10}, 32'h0);
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0; br_type = 3'b110; br_idx = 4'd3;
        step();
        chk("lut3_cleared", 32'(pc10), 32'h0);
        // same-index write and read: old entry first, new one next cycle
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'h123;
        step();
        lut_we = 1'b0;
        chk("lut_old_on_write", 32'(pc10), 32'h0);
        step();
        chk("lut_new_next", 32'(pc10), 32'h123);
        br_type = 3'b000;
        step();
        chk("after_jmp", 32'(pc10), 32'h124);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
